// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stage bundle widths and a width helper for counters/pointers.
package pipe_pkg;

   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 117;
   localparam int EX_MEM_W = 39;
   localparam int MEM_WB_W = 70;

   localparam int COUNT_W  = 5;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// Stage-to-stage bundle with valid/allow handshakes, flush and debug counters.
interface pipe_elastic_stage_if #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
);
   import pipe_pkg::*;

   logic                flush;
   logic                in_valid;
   logic                in_allow;
   logic [DATA_W-1:0]   in_data;
   logic                out_valid;
   logic                out_allow;
   logic [DATA_W-1:0]   out_data;
   logic [COUNT_W-1:0]  count;
   logic [CNT_W-1:0]    flush_drop_cnt;

   modport slave (
      input  flush, in_valid, in_data, out_allow,
      output in_allow, out_valid, out_data, count, flush_drop_cnt
   );

   modport master (
      output flush, in_valid, in_data, out_allow,
      input  in_allow, out_valid, out_data, count, flush_drop_cnt
   );
endinterface

// File: rtl/pipe_buf_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module pipe_buf_ram #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic inter-stage FIFO: 1-cycle latency (0 with BYPASS when empty); in_allow is purely
// registered (count != DEPTH), so a full buffer refuses input even while it drains.
module pipe_elastic_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 0,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_elastic_stage_if.slave  bus
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int SUM_W = ((CNT_W > COUNT_W) ? CNT_W : COUNT_W) + 1;
   localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   DROP_MAX = '1;

   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [COUNT_W-1:0] cnt;
   logic [CNT_W-1:0]   drop_cnt, drop_next;
   logic [SUM_W-1:0]   drop_sum;
   logic [DATA_W-1:0]  head;
   logic               empty, bypass_hit, push, pop;

   assign empty       = (cnt == '0);
   assign bus.in_allow = (cnt != FULL_CNT);

   assign bypass_hit = (BYPASS != 0) && empty && bus.in_valid && bus.out_allow && !bus.flush;
   assign push       = bus.in_valid && bus.in_allow && !bus.flush && !bypass_hit;
   assign pop        = bus.out_valid && bus.out_allow && !bypass_hit && !bus.flush;

   // Flush hides the head from downstream so nothing is accepted during a squash.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      if (!empty) begin
         bus.out_valid = !bus.flush;
         bus.out_data  = head;
      end else if (BYPASS != 0) begin
         bus.out_valid = !bus.flush && bus.in_valid;
         bus.out_data  = bus.in_data;
      end
   end

   // Widened sum so small CNT_W still saturates correctly when count exceeds its range.
   always_comb begin
      drop_sum  = SUM_W'(drop_cnt) + SUM_W'(cnt) + SUM_W'(bus.in_valid && bus.in_allow);
      drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         drop_cnt <= '0;
      end else if (bus.flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         drop_cnt <= drop_next;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign bus.count          = cnt;
   assign bus.flush_drop_cnt = drop_cnt;

   pipe_buf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (bus.in_data),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Four buffer configurations checked every cycle against a queue-based reference model.
module tb_pipe_elastic_stage;

   localparam int N  = 4;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic          flush_d [N];
   logic          ival    [N];
   logic          oallow  [N];
   logic [DW-1:0] idata   [N];
   logic          ov      [N];
   logic          ia      [N];
   logic [DW-1:0] od      [N];
   logic [4:0]    cnt_o   [N];
   logic [15:0]   drop_o  [N];

   pipe_elastic_stage_if #(.DATA_W(DW), .CNT_W(16)) b0 ();
   pipe_elastic_stage_if #(.DATA_W(DW), .CNT_W(16)) b1 ();
   pipe_elastic_stage_if #(.DATA_W(DW), .CNT_W(16)) b2 ();
   pipe_elastic_stage_if #(.DATA_W(DW), .CNT_W(2))  b3 ();

   pipe_elastic_stage #(.DATA_W(DW), .DEPTH(2), .BYPASS(0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
   pipe_elastic_stage #(.DATA_W(DW), .DEPTH(3), .BYPASS(0), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
   pipe_elastic_stage #(.DATA_W(DW), .DEPTH(2), .BYPASS(1), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .bus(b2));
   pipe_elastic_stage #(.DATA_W(DW), .DEPTH(2), .BYPASS(0), .CNT_W(2))  u3 (.clk(clk), .reset(reset), .bus(b3));

   assign b0.flush = flush_d[0]; assign b0.in_valid = ival[0]; assign b0.in_data = idata[0]; assign b0.out_allow = oallow[0];
   assign b1.flush = flush_d[1]; assign b1.in_valid = ival[1]; assign b1.in_data = idata[1]; assign b1.out_allow = oallow[1];
   assign b2.flush = flush_d[2]; assign b2.in_valid = ival[2]; assign b2.in_data = idata[2]; assign b2.out_allow = oallow[2];
   assign b3.flush = flush_d[3]; assign b3.in_valid = ival[3]; assign b3.in_data = idata[3]; assign b3.out_allow = oallow[3];

   assign ov[0] = b0.out_valid; assign ia[0] = b0.in_allow; assign od[0] = b0.out_data; assign cnt_o[0] = b0.count;
   assign ov[1] = b1.out_valid; assign ia[1] = b1.in_allow; assign od[1] = b1.out_data; assign cnt_o[1] = b1.count;
   assign ov[2] = b2.out_valid; assign ia[2] = b2.in_allow; assign od[2] = b2.out_data; assign cnt_o[2] = b2.count;
   assign ov[3] = b3.out_valid; assign ia[3] = b3.in_allow; assign od[3] = b3.out_data; assign cnt_o[3] = b3.count;
   assign drop_o[0] = b0.flush_drop_cnt;
   assign drop_o[1] = b1.flush_drop_cnt;
   assign drop_o[2] = b2.flush_drop_cnt;
   assign drop_o[3] = {14'd0, b3.flush_drop_cnt};

   // Reference model: contents as a plain queue, drops as an integer total.
   logic [DW-1:0] mq [N][$];
   int            mdrop [N];

   function automatic int dep(input int i);
      return (i == 1) ? 3 : 2;
   endfunction

   function automatic bit byp(input int i);
      return (i == 2);
   endfunction

   function automatic int dmax(input int i);
      return (i == 3) ? 3 : 65535;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set(input int i, input bit f, input bit v, input bit a, input logic [DW-1:0] d);
      flush_d[i] = f;
      ival[i]    = v;
      oallow[i]  = a;
      idata[i]   = d;
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) set(i, 1'b0, 1'b0, 1'b1, '0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         mdrop[i] = 0;
      end
   endtask

   // Called with inputs settled; checks all outputs, advances the model, moves to next negedge.
   task automatic step();
      for (int i = 0; i < N; i++) begin
         int            c;
         int            nd;
         bit            ev;
         bit            acc;
         logic [DW-1:0] ed;
         c  = mq[i].size();
         ev = 1'b0;
         ed = '0;
         if (c != 0) begin
            ev = !flush_d[i];
            ed = mq[i][0];
         end else if (byp(i)) begin
            ev = !flush_d[i] && ival[i];
            ed = idata[i];
         end
         chk($sformatf("u%0d_count", i), 32'(cnt_o[i]), 32'(c));
         chk($sformatf("u%0d_in_allow", i), 32'(ia[i]), 32'(c != dep(i)));
         chk($sformatf("u%0d_out_valid", i), 32'(ov[i]), 32'(ev));
         if (ev || (c == 0 && !byp(i)))
            chk($sformatf("u%0d_out_data", i), 32'(od[i]), 32'(ed));
         chk($sformatf("u%0d_drop_cnt", i), 32'(drop_o[i]), 32'(mdrop[i]));

         acc = ival[i] && (c != dep(i));
         if (flush_d[i]) begin
            nd = mdrop[i] + c + int'(acc);
            mdrop[i] = (nd > dmax(i)) ? dmax(i) : nd;
            mq[i].delete();
         end else if (!(c == 0 && byp(i) && ival[i] && oallow[i])) begin
            if (c != 0 && oallow[i]) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(idata[i]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int nxt;
      int expv;

      idle_all();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_out_valid", 32'(ov[0]), 32'd0);
      chk("reset_in_allow", 32'(ia[0]), 32'd1);
      reset = 1'b0;
      #1;
      step();

      // Fill the depth-2 buffer with downstream stalled, then release.
      set(0, 0, 1, 0, 16'hA1); #1; step();
      set(0, 0, 1, 0, 16'hA2); #1; step();
      chk("fill_count", 32'(cnt_o[0]), 32'd2);
      chk("fill_in_allow", 32'(ia[0]), 32'd0);
      set(0, 0, 1, 0, 16'hA3); #1; step();
      set(0, 0, 1, 1, 16'hA3); #1;
      chk("drain_first", 32'(od[0]), 32'hA1);
      chk("full_pop_no_allow", 32'(ia[0]), 32'd0);
      step();
      set(0, 0, 1, 1, 16'hA3); #1;
      chk("drain_second", 32'(od[0]), 32'hA2);
      step();
      set(0, 0, 0, 1, 16'h0); #1;
      chk("drain_third", 32'(od[0]), 32'hA3);
      step();

      // Depth-3 wrap with a toggling downstream.
      nxt  = 1;
      expv = 1;
      for (int k = 0; k < 60 && expv <= 10; k++) begin
         set(1, 0, nxt <= 10, (k % 2) == 0, DW'(nxt)); #1;
         if (ov[1] && oallow[1]) begin
            chk("wrap_order", 32'(od[1]), 32'(expv));
            expv++;
         end
         if (ia[1] && ival[1]) nxt++;
         step();
      end
      chk("wrap_done", 32'(expv), 32'd11);

      // Flush with two held and one arriving.
      set(1, 0, 1, 0, 16'hB1); #1; step();
      set(1, 0, 1, 0, 16'hB2); #1; step();
      set(1, 1, 1, 1, 16'hB3); #1;
      chk("flush_hides_valid", 32'(ov[1]), 32'd0);
      step();
      set(1, 0, 0, 1, 16'h0); #1;
      chk("flush_count", 32'(cnt_o[1]), 32'd0);
      chk("flush_out_valid", 32'(ov[1]), 32'd0);
      chk("flush_drop", 32'(drop_o[1]), 32'd3);
      step();

      // Empty bypass, then enqueue when downstream stalls.
      set(2, 0, 1, 1, 16'h55); #1;
      chk("bypass_data", 32'(od[2]), 32'h55);
      chk("bypass_valid", 32'(ov[2]), 32'd1);
      step();
      set(2, 0, 1, 0, 16'h55); #1;
      chk("bypass_count0", 32'(cnt_o[2]), 32'd0);
      step();
      set(2, 0, 0, 0, 16'h0); #1;
      chk("bypass_enq_count", 32'(cnt_o[2]), 32'd1);
      chk("bypass_enq_data", 32'(od[2]), 32'h55);
      step();
      set(2, 0, 0, 1, 16'h0); #1; step();

      // Narrow drop counter saturation: 2, 4->3, 6->3.
      for (int r = 0; r < 3; r++) begin
         set(3, 0, 1, 0, DW'(16'hC0 + r)); #1; step();
         set(3, 0, 1, 0, DW'(16'hD0 + r)); #1; step();
         set(3, 1, 0, 0, 16'h0); #1; step();
         set(3, 0, 0, 1, 16'h0); #1;
         chk($sformatf("sat_drop_%0d", r), 32'(drop_o[3]), (r == 0) ? 32'd2 : 32'd3);
         step();
      end

      // Reset mid-stream with two entries held.
      set(0, 0, 1, 0, 16'hE1); #1; step();
      set(0, 0, 1, 0, 16'hE2); #1; step();
      set(0, 0, 0, 0, 16'h0);
      reset = 1'b1;
      #1;
      chk("midreset_out_valid", 32'(ov[0]), 32'd0);
      chk("midreset_count", 32'(cnt_o[0]), 32'd0);
      chk("midreset_in_allow", 32'(ia[0]), 32'd1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_all();
      #1;
      step();

      // Randomised traffic on all four configurations.
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++)
            set(i, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 6, DW'($urandom));
         #1;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
